// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams two RAM-resident vectors into the shared MAC
// with first-beat accumulator restart, then returns the scaled sum over valid/ready.
module mac_dot_seq #(
    parameter int T_WIDTH    = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic        [LEN_WIDTH-1:0]  len,
    input  logic        [ADDR_WIDTH-1:0] base_a,
    input  logic        [ADDR_WIDTH-1:0] base_b,
    input  logic        [2:0]            mode_in,
    output logic                         busy,
    output logic                         err,
    output logic                         mem_a_en,
    output logic                         mem_b_en,
    output logic        [ADDR_WIDTH-1:0] mem_a_addr,
    output logic        [ADDR_WIDTH-1:0] mem_b_addr,
    input  logic        [T_WIDTH-1:0]    mem_a_rdata,
    input  logic        [T_WIDTH-1:0]    mem_b_rdata,
    output logic signed [T_WIDTH-1:0]    mac_in_1,
    output logic signed [T_WIDTH-1:0]    mac_in_2,
    output logic                         mac_in_valid,
    output logic                         mac_reset,
    output logic        [2:0]            mac_mode,
    input  logic signed [T_WIDTH-1:0]    mac_out,
    input  logic                         mac_out_valid,
    output logic signed [T_WIDTH-1:0]    result,
    output logic                         result_valid,
    input  logic                         result_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  idx;
    logic [2:0]            mode_q;
    logic [1:0]            last_tag;
    logic                  issue_first;
    logic                  issue_last;

    assign busy        = (state != IDLE);
    assign mem_a_en    = (state == ISSUE);
    assign mem_b_en    = (state == ISSUE);
    assign mac_mode    = mode_q;
    assign mac_in_1    = $signed(mem_a_rdata);
    assign mac_in_2    = $signed(mem_b_rdata);
    assign issue_first = (state == ISSUE) && (idx == '0);
    assign issue_last  = (state == ISSUE) && (idx == len_q - LEN_WIDTH'(1));

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            len_q        <= '0;
            idx          <= '0;
            mode_q       <= '0;
            mem_a_addr   <= '0;
            mem_b_addr   <= '0;
            mac_in_valid <= 1'b0;
            mac_reset    <= 1'b0;
            last_tag     <= '0;
            err          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            err          <= 1'b0;
            // Beat pipe: one stage matches the RAM read latency; the last-beat
            // tag gets a second stage for the MAC accumulator register.
            mac_in_valid <= (state == ISSUE);
            mac_reset    <= issue_first;
            last_tag     <= {last_tag[0], issue_last};

            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode_in[2]) begin
                            err <= 1'b1;
                        end else begin
                            len_q      <= len;
                            mode_q     <= mode_in;
                            idx        <= '0;
                            mem_a_addr <= base_a;
                            mem_b_addr <= base_b;
                            if (len != '0) begin
                                state <= ISSUE;
                            end else begin
                                result <= '0;
                                state  <= HOLD;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (issue_last) begin
                        state <= DRAIN;
                    end else begin
                        idx        <= idx + LEN_WIDTH'(1);
                        mem_a_addr <= mem_a_addr + ADDR_WIDTH'(1);
                        mem_b_addr <= mem_b_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (last_tag[1]) begin
                        result       <= mac_out;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        result_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The MAC must present a valid output on the edge where the sum is captured.
    assert property (@(posedge clk) disable iff (!rst)
        (state == DRAIN && last_tag[1]) |-> mac_out_valid);

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: behavioural RAMs and MAC around the DUT, directed and
// random dot products checked against a plain-arithmetic reference sum.
module tb_mac_dot_seq;

    localparam int T_WIDTH    = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int LEN_WIDTH  = 10;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         start;
    logic        [LEN_WIDTH-1:0]  len;
    logic        [ADDR_WIDTH-1:0] base_a;
    logic        [ADDR_WIDTH-1:0] base_b;
    logic        [2:0]            mode_in;
    logic                         busy;
    logic                         err;
    logic                         mem_a_en;
    logic                         mem_b_en;
    logic        [ADDR_WIDTH-1:0] mem_a_addr;
    logic        [ADDR_WIDTH-1:0] mem_b_addr;
    logic        [T_WIDTH-1:0]    mem_a_rdata = '0;
    logic        [T_WIDTH-1:0]    mem_b_rdata = '0;
    logic signed [T_WIDTH-1:0]    mac_in_1;
    logic signed [T_WIDTH-1:0]    mac_in_2;
    logic                         mac_in_valid;
    logic                         mac_reset;
    logic        [2:0]            mac_mode;
    logic signed [T_WIDTH-1:0]    mac_out;
    logic                         mac_out_valid = 1'b0;
    logic signed [T_WIDTH-1:0]    result;
    logic                         result_valid;
    logic                         result_ready;

    int checks = 0;
    int errors = 0;

    logic [T_WIDTH-1:0] mem_a [DEPTH];
    logic [T_WIDTH-1:0] mem_b [DEPTH];
    longint             acc = 0;

    always #5 clk = ~clk;

    mac_dot_seq #(
        .T_WIDTH   (T_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .base_a       (base_a),
        .base_b       (base_b),
        .mode_in      (mode_in),
        .busy         (busy),
        .err          (err),
        .mem_a_en     (mem_a_en),
        .mem_b_en     (mem_b_en),
        .mem_a_addr   (mem_a_addr),
        .mem_b_addr   (mem_b_addr),
        .mem_a_rdata  (mem_a_rdata),
        .mem_b_rdata  (mem_b_rdata),
        .mac_in_1     (mac_in_1),
        .mac_in_2     (mac_in_2),
        .mac_in_valid (mac_in_valid),
        .mac_reset    (mac_reset),
        .mac_mode     (mac_mode),
        .mac_out      (mac_out),
        .mac_out_valid(mac_out_valid),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // MAC output scaling: mode selects a right shift of the accumulator.
    function automatic int shift_of(input logic [2:0] m);
        case (m[1:0])
            2'd0:    return 0;
            2'd1:    return 16;
            2'd2:    return 8;
            default: return 24;
        endcase
    endfunction

    // Synchronous-read operand RAMs.
    always_ff @(posedge clk) begin
        if (mem_a_en) mem_a_rdata <= mem_a[mem_a_addr];
        if (mem_b_en) mem_b_rdata <= mem_b[mem_b_addr];
    end

    // Shared MAC: registered accumulator, combinational scaled output.
    always_ff @(posedge clk) begin
        mac_out_valid <= rst && mac_in_valid;
        if (mac_in_valid)
            acc <= (mac_reset ? 64'sd0 : acc) + longint'(mac_in_1) * longint'(mac_in_2);
    end
    assign mac_out = T_WIDTH'(acc >>> shift_of(mac_mode));

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {busy, err, mem_a_en, mem_b_en, mem_a_addr, mem_b_addr,
                    mac_in_valid, mac_reset, mac_mode, result, result_valid}, 0);
    endtask

    function automatic logic [T_WIDTH-1:0] rand_operand();
        return T_WIDTH'($signed(16'($urandom)));
    endfunction

    // Issue one command, follow it to completion, hold backpressure for
    // `hold` cycles (with ignored start pulses), then complete the handshake.
    task automatic run_op(input string tag, input int n, input int ba, input int bb,
                          input int mode, input int hold);
        logic signed [63:0] sum;
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        logic signed [T_WIDTH-1:0] exp_r;
        int  cyc, beats, resets, reset_beat, naddr;
        bit  got, addr_bad, mode_bad, hold_bad;

        sum = 0;
        for (int i = 0; i < n; i++) begin
            pa  = $signed(mem_a[(ba + i) % DEPTH]);
            pb  = $signed(mem_b[(bb + i) % DEPTH]);
            sum = sum + pa * pb;
        end
        exp_r = T_WIDTH'(sum >>> shift_of(3'(mode)));

        start   = 1'b1;
        len     = LEN_WIDTH'(n);
        base_a  = ADDR_WIDTH'(ba);
        base_b  = ADDR_WIDTH'(bb);
        mode_in = 3'(mode);
        step();
        start = 1'b0;
        check({tag, " busy after start"}, busy, 1);

        cyc = 0; beats = 0; resets = 0; reset_beat = 0; naddr = 0;
        got = 0; addr_bad = 0; mode_bad = 0;
        while (cyc < n + 50) begin
            if (mem_a_en || mem_b_en) begin
                if (!(mem_a_en && mem_b_en) ||
                    mem_a_addr != ADDR_WIDTH'((ba + naddr) % DEPTH) ||
                    mem_b_addr != ADDR_WIDTH'((bb + naddr) % DEPTH))
                    addr_bad = 1;
                naddr++;
            end
            if (mac_in_valid) begin
                beats++;
                if (mac_reset) begin
                    resets++;
                    reset_beat = beats;
                end
            end else if (mac_reset) begin
                resets += 100;
            end
            if (mac_mode != 3'(mode)) mode_bad = 1;
            if (result_valid) begin
                got = 1;
                break;
            end
            step();
            cyc++;
        end

        check({tag, " latency"}, got ? cyc : -1, (n == 0) ? 1 : n + 2);
        check({tag, " result"}, result, exp_r);
        check({tag, " beats"}, beats, n);
        check({tag, " mac_reset count"}, resets, (n == 0) ? 0 : 1);
        check({tag, " mac_reset beat"}, reset_beat, (n == 0) ? 0 : 1);
        check({tag, " ram reads"}, naddr, n);
        check({tag, " address sequence bad"}, addr_bad, 0);
        check({tag, " mac_mode unstable"}, mode_bad, 0);

        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            start   = 1'b1;
            mode_in = 3'd5;
            len     = LEN_WIDTH'(1);
            step();
            if (!result_valid || result !== exp_r || err || !busy) hold_bad = 1;
        end
        start = 1'b0;
        if (hold > 0) check({tag, " backpressure hold bad"}, hold_bad, 0);

        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, " handshake valid/busy"}, {result_valid, busy}, 0);
        check({tag, " result held"}, result, exp_r);
    endtask

    initial begin
        int n, ba, bb, md, hd;

        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = rand_operand();
            mem_b[i] = rand_operand();
        end
        rst          = 1'b0;
        start        = 1'b1;
        len          = LEN_WIDTH'(4);
        base_a       = '0;
        base_b       = '0;
        mode_in      = 3'd0;
        result_ready = 1'b0;

        // Reset with start asserted.
        repeat (3) step();
        check_all_zero("reset outputs");
        start = 1'b0;
        rst   = 1'b1;
        step();
        check("start during reset ignored", busy, 0);

        // Basic dot product.
        for (int i = 0; i < 4; i++) begin
            mem_a[i]       = T_WIDTH'(i + 1);
            mem_b[100 + i] = T_WIDTH'(i + 5);
        end
        run_op("basic", 4, 0, 100, 0, 0);
        check("basic value", result, 70);

        // Back-to-back with backpressure, then no accumulator carry-over.
        mem_a[10] = T_WIDTH'(3);
        mem_a[11] = T_WIDTH'(-4);
        mem_b[20] = T_WIDTH'(2);
        mem_b[21] = T_WIDTH'(5);
        run_op("b2b first", 2, 10, 20, 0, 5);
        check("b2b first value", result, -14);
        mem_a[30] = T_WIDTH'(7);
        mem_b[40] = T_WIDTH'(7);
        run_op("b2b second", 1, 30, 40, 0, 0);
        check("b2b second value", result, 49);

        // Zero length.
        run_op("len0", 0, 5, 6, 2, 1);

        // Illegal mode.
        start   = 1'b1;
        mode_in = 3'd5;
        len     = LEN_WIDTH'(3);
        step();
        start = 1'b0;
        check("illegal mode err/busy/en", {err, busy, mem_a_en}, 3'b100);
        step();
        check("illegal mode err single pulse", {err, busy}, 0);

        // Address wrap.
        run_op("wrap", 4, 1022, 500, 0, 0);

        // 16.16 scaling.
        mem_a[200] = 32'h0001_8000;
        mem_b[300] = 32'h0002_0000;
        run_op("mode1", 1, 200, 300, 1, 2);
        check("mode1 value", result, 32'h0003_0000);

        // Abort mid-ISSUE.
        start   = 1'b1;
        len     = LEN_WIDTH'(8);
        base_a  = ADDR_WIDTH'(600);
        base_b  = ADDR_WIDTH'(700);
        mode_in = 3'd1;
        step();
        start = 1'b0;
        step();
        step();
        check("abort mid-issue reached", mem_a_en, 1);
        rst = 1'b0;
        step();
        check_all_zero("abort outputs");
        rst = 1'b1;
        step();
        run_op("after abort", 2, 650, 750, 0, 0);

        // Random commands.
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 12);
            ba = $urandom_range(0, DEPTH - 1);
            bb = $urandom_range(0, DEPTH - 1);
            md = $urandom_range(0, 3);
            hd = $urandom_range(0, 3);
            run_op($sformatf("rand%0d", r), n, ba, bb, md, hd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer that computes one dot product at a time on the shared fixed-point MAC. It fetches two operand vectors from synchronous-read memories and streams them into the MAC with correct `mac_reset` / `in_valid` framing. It then captures the scaled MAC output and returns it through a valid/ready result port. It sits between the layer controller, which issues start commands, and the MAC instance with its two operand RAMs.

## Interface
Parameters:
- `T_WIDTH`, 32: operand/result width; matches the MAC's `T_WIDTH`.
- `ADDR_WIDTH`, 10: operand RAM address width.
- `LEN_WIDTH`, 10: vector length field width.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: command strobe, accepted only in IDLE.
- `len` in LEN_WIDTH: number of element pairs (0 allowed).
- `base_a` / `base_b` in ADDR_WIDTH: start addresses of vectors A and B.
- `mode_in` in 3: MAC scaling mode; legal values are 0–3.
- `busy` out 1: high when state ≠ IDLE.
- `err` out 1: one-cycle pulse when start is rejected.
- `mem_a_en`, `mem_b_en` out 1: RAM read enables.
- `mem_a_addr`, `mem_b_addr` out ADDR_WIDTH: RAM read addresses.
- `mem_a_rdata`, `mem_b_rdata` in T_WIDTH: read data, valid the cycle after the enabled edge.
- `mac_in_1`, `mac_in_2` out T_WIDTH signed: MAC operands, driven from `mem_a_rdata` / `mem_b_rdata`.
- `mac_in_valid` out 1: MAC input valid.
- `mac_reset` out 1: MAC accumulator restart; high only on the first beat.
- `mac_mode` out 3: MAC mode.
- `mac_out` in T_WIDTH signed: scaled MAC output, combinational from the accumulator.
- `mac_out_valid` in 1: MAC valid; monitored for assertion checking only.
- `result` out T_WIDTH signed: captured dot product.
- `result_valid` out 1 / `result_ready` in 1: result handshake.

## Operation
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE, `start`=1, `mode_in[2]`=1:
  - Pulse `err` for one cycle.
  - Stay in IDLE; no other effect.
- IDLE, `start`=1, legal mode:
  - Latch `len`, `base_a`, `base_b` and `mode_in`, and clear index `i`.
  - Go to ISSUE if `len`≠0.
  - If `len`=0, load `result`=0 and go to HOLD; no RAM or MAC activity.
- ISSUE, each cycle:
  - Drive `mem_*_en`=1, `mem_a_addr`=`base_a`+i, `mem_b_addr`=`base_b`+i. Addresses wrap modulo 2^ADDR_WIDTH.
  - Push a valid bit and a first bit (i==0) into a 1-deep pipe aligned with RAM latency.
  - At i==len−1, go to DRAIN.
- Beat pipe output drives `mac_in_valid` and `mac_reset` (registered). `mac_in_1`/`mac_in_2` are wired directly from the RAM read data.
- DRAIN:
  - Wait for a 2-stage last-beat tag (RAM latency plus MAC accumulator register).
  - When the tag fires, capture `mac_out` into `result` and go to HOLD.
- HOLD:
  - `result_valid`=1.
  - On an edge with `result_ready`=1, clear `result_valid` and go to IDLE.
  - `result` holds its value until the next capture.
- `mac_mode` is driven from the latched mode from start through capture, and held while IDLE. This matters because MAC output scaling is combinational on mode.
- When idle, `mac_in_valid`=0 and `mac_reset`=0, so the MAC accumulates zero and holds. Each new operation restarts the accumulator through `mac_reset` on its first beat, so there is no dependence on the previous accumulator contents.
- `start` outside IDLE is ignored: no `err`, no effect.

## Timing
- Reset (`rst`=0 at an edge), from any state, including mid-ISSUE or mid-DRAIN:
  - State goes to IDLE.
  - `busy`, `err`, `mem_*_en`, `mem_*_addr`, `mac_in_valid`, `mac_reset`, `mac_mode`, `result` and `result_valid` all become 0.
  - All pipe bits are cleared.
- Start accepted at edge k, `len`=N≥1:
  - Addresses for element i are driven in the cycle after edge k+i.
  - `mac_in_valid` is high for cycles after edges k+1 … k+N; `mac_reset` is high only after edge k+1.
  - The final accumulator update happens at edge k+N+1.
  - `result` is captured at edge k+N+2, and `result_valid` is first high after edge k+N+2.
  - Latency is N+2 cycles; throughput is one element per cycle with no gaps.
- `len`=0: `result_valid` is high after edge k+1.
- `busy` rises after edge k and falls after the edge where the handshake completes.
- Earliest next `start` is the cycle after `busy` falls.

## Test plan
- Reset values: hold `rst`=0 for 3 cycles → every output is 0 and state is IDLE; `start` during reset is ignored.
- Basic dot product: A=[1,2,3,4], B=[5,6,7,8], mode 0, `len`=4, `result_ready`=1 → `mac_reset` on beat 1 only; `result`=70; `result_valid` rises 6 cycles after start.
- Back-to-back with backpressure: run `len`=2 (A=[3,−4], B=[2,5]) → `result`=−14. Hold `result_ready`=0 for 5 cycles: `result_valid` and `result` stay stable, `start` is ignored. Next op `len`=1 (A=[7], B=[7]) → `result`=49, with no carry-over from the previous accumulator.
- Edge cases:
  - `len`=0 → `result`=0 one cycle after start, `mem_*_en` never asserted.
  - `mode_in`=5 → `err` pulses once, `busy` stays 0.
  - `base_a`=1022, `len`=4 → addresses 1022, 1023, 0, 1.
- Mode scaling: mode 1 with 16.16 operands 1.5 × 2.0, `len`=1 → `result`=0x0003_0000; `mac_mode` is stable through the capture edge.
- Abort: `rst`=0 mid-ISSUE of a `len`=8 op → all outputs are 0 next cycle. A new `len`=2 op after reset returns the correct sum.
